// File: rtl/change_dispenser_if.sv
// Handshake/bus bundle between the vending-machine core and change_dispenser.
// master drives the request side (machine / bench); slave is the dispenser.
interface change_dispenser_if #(
  parameter int kNumCoins  = 3,
  parameter int kTotalBits = 31
);
  logic                  i_trigger_return;
  logic [kTotalBits-1:0] current_total;
  logic [31:0]           wait_time;
  logic [kNumCoins-1:0]  o_return_coin;
  logic                  o_returning;
  logic                  o_done;
  logic [kTotalBits-1:0] o_remainder;

  modport master (
    output i_trigger_return, current_total, wait_time,
    input  o_return_coin, o_returning, o_done, o_remainder
  );

  modport slave (
    input  i_trigger_return, current_total, wait_time,
    output o_return_coin, o_returning, o_done, o_remainder
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change-return engine: snapshots the balance on a trigger and pays it out largest coin first.
// Optional MULTI_COIN_RETURN_EN: up to one coin of each denomination per cycle instead of one coin total.
module change_dispenser #(
  parameter int          kNumCoins   = 3,
  parameter int          kTotalBits  = 31,
  parameter int unsigned COIN0_VALUE = 100,
  parameter int unsigned COIN1_VALUE = 500,
  parameter int unsigned COIN2_VALUE = 1000
) (
  input logic               clk,
  input logic               reset_n,
  change_dispenser_if.slave bus
);

  localparam logic [kTotalBits-1:0] kCoin0 = kTotalBits'(COIN0_VALUE);
  localparam logic [kTotalBits-1:0] kCoin1 = kTotalBits'(COIN1_VALUE);
  localparam logic [kTotalBits-1:0] kCoin2 = kTotalBits'(COIN2_VALUE);

  typedef enum logic [1:0] {
    IDLE,
    DISPENSE,
    DONE
  } state_t;

  state_t                state;
  logic [kTotalBits-1:0] remaining;
  logic [kNumCoins-1:0]  coin;
  logic [kTotalBits-1:0] left;
  logic                  trigger;

  assign trigger = bus.i_trigger_return ||
                   ((bus.wait_time == 32'd0) && (bus.current_total >= kCoin0));

  // Greedy decode of this cycle's coins; `left` is the balance after paying them.
  // NOTE: always_comb uses blocking assignments and defaults every output first, so
  // the chained `left` updates read in order and no latch is inferred.
  always_comb begin
    coin = '0;
    left = remaining;
`ifdef MULTI_COIN_RETURN_EN
    if (left >= kCoin2) begin
      coin[2] = 1'b1;
      left    = left - kCoin2;
    end
    if (left >= kCoin1) begin
      coin[1] = 1'b1;
      left    = left - kCoin1;
    end
    if (left >= kCoin0) begin
      coin[0] = 1'b1;
      left    = left - kCoin0;
    end
`else
    if (remaining >= kCoin2) begin
      coin[2] = 1'b1;
      left    = remaining - kCoin2;
    end else if (remaining >= kCoin1) begin
      coin[1] = 1'b1;
      left    = remaining - kCoin1;
    end else if (remaining >= kCoin0) begin
      coin[0] = 1'b1;
      left    = remaining - kCoin0;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            remaining <= bus.current_total;
            state     <= (bus.current_total >= kCoin0) ? DISPENSE : DONE;
          end
        end
        DISPENSE: begin
          remaining <= left;
          if (left < kCoin0) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from the state register, so reset clears them at once.
  assign bus.o_return_coin = (state == DISPENSE) ? coin : '0;
  assign bus.o_returning   = (state == DISPENSE);
  assign bus.o_done        = (state == DONE);
  assign bus.o_remainder   = (state == DONE) ? remaining : '0;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized self-checking bench for change_dispenser against a payout model built from coin counts.
// Honours MULTI_COIN_RETURN_EN the same way the design does.
module tb_change_dispenser;

  localparam int unsigned kC0 = 100;
  localparam int unsigned kC1 = 500;
  localparam int unsigned kC2 = 1000;

  logic clk;
  logic reset_n;

  change_dispenser_if #(.kNumCoins(3), .kTotalBits(31)) bus ();

  change_dispenser #(
    .kNumCoins  (3),
    .kTotalBits (31),
    .COIN0_VALUE(kC0),
    .COIN1_VALUE(kC1),
    .COIN2_VALUE(kC2)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Reference payout: the list of coin vectors for one return plus the leftover.
  logic [2:0]  exp_q[$];
  int unsigned exp_rem;

  task automatic model(input int unsigned total);
    int unsigned v;
    logic [2:0]  c;
    exp_q.delete();
    v = total;
`ifdef MULTI_COIN_RETURN_EN
    while (v >= kC0) begin
      c = 3'b000;
      if (v >= kC2) begin c[2] = 1'b1; v -= kC2; end
      if (v >= kC1) begin c[1] = 1'b1; v -= kC1; end
      if (v >= kC0) begin c[0] = 1'b1; v -= kC0; end
      exp_q.push_back(c);
    end
`else
    begin
      int unsigned n2, n1, n0;
      n2 = v / kC2; v = v % kC2;
      n1 = v / kC1; v = v % kC1;
      n0 = v / kC0; v = v % kC0;
      repeat (n2) exp_q.push_back(3'b100);
      repeat (n1) exp_q.push_back(3'b010);
      repeat (n0) exp_q.push_back(3'b001);
    end
`endif
    exp_rem = v;
  endtask

  function automatic int unsigned coin_sum(input logic [2:0] c);
    return (c[2] ? kC2 : 0) + (c[1] ? kC1 : 0) + (c[0] ? kC0 : 0);
  endfunction

  // Starts and ends on a falling edge; the machine balance drops by each paid coin.
  task automatic run_return(input int unsigned total, input bit by_timer, input string tag);
    model(total);
    bus.current_total = 31'(total);
    if (by_timer) bus.wait_time = 32'd0;
    else          bus.i_trigger_return = 1'b1;
    @(negedge clk);
    bus.i_trigger_return = 1'b0;
    bus.wait_time        = 32'd1000;
    foreach (exp_q[i]) begin
      check({tag, " coin"},      32'(bus.o_return_coin), 32'(exp_q[i]));
      check({tag, " returning"}, 32'(bus.o_returning), 32'd1);
      check({tag, " done_early"}, 32'(bus.o_done), 32'd0);
      bus.current_total = bus.current_total - 31'(coin_sum(exp_q[i]));
      @(negedge clk);
    end
    check({tag, " done"},      32'(bus.o_done), 32'd1);
    check({tag, " remainder"}, 32'(bus.o_remainder), exp_rem);
    check({tag, " done_coin"}, 32'(bus.o_return_coin), 32'd0);
    check({tag, " done_ret"},  32'(bus.o_returning), 32'd0);
    @(negedge clk);
    check({tag, " idle_done"}, 32'(bus.o_done), 32'd0);
    check({tag, " idle_ret"},  32'(bus.o_returning), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_trigger_return = 1'b0;
    bus.current_total    = '0;
    bus.wait_time        = 32'd1000;
    reset_n              = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("rst coin",      32'(bus.o_return_coin), 32'd0);
    check("rst returning", 32'(bus.o_returning), 32'd0);
    check("rst done",      32'(bus.o_done), 32'd0);
    check("rst remainder", 32'(bus.o_remainder), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_return(1700, 1'b0, "t1700");

    // Sub-coin balance: immediate done, then no timer re-trigger.
    run_return(50, 1'b0, "t50");
    bus.current_total = 31'd50;
    bus.wait_time     = 32'd0;
    repeat (4) begin
      @(negedge clk);
      check("t50 no_retrig done", 32'(bus.o_done), 32'd0);
      check("t50 no_retrig ret",  32'(bus.o_returning), 32'd0);
    end
    bus.wait_time = 32'd1000;

    run_return(600, 1'b1, "timer600");

    // Reset abandons the sequence after the second coin.
    model(3000);
    bus.current_total    = 31'd3000;
    bus.i_trigger_return = 1'b1;
    @(negedge clk);
    bus.i_trigger_return = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("rst_mid coin", 32'(bus.o_return_coin), 32'(exp_q[i]));
      bus.current_total = bus.current_total - 31'(coin_sum(exp_q[i]));
      @(negedge clk);
    end
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid coin0", 32'(bus.o_return_coin), 32'd0);
    check("rst_mid ret0",  32'(bus.o_returning), 32'd0);
    check("rst_mid done0", 32'(bus.o_done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_mid idle ret",  32'(bus.o_returning), 32'd0);
      check("rst_mid idle done", 32'(bus.o_done), 32'd0);
    end
    bus.current_total = '0;

    // Held trigger with coins inserted mid-return.
    bus.current_total    = 31'd1000;
    bus.i_trigger_return = 1'b1;
    @(negedge clk);
    check("hold coin1", 32'(bus.o_return_coin), 32'b100);
    bus.current_total = bus.current_total - 31'd1000 + 31'd500;
    @(negedge clk);
    check("hold done1", 32'(bus.o_done), 32'd1);
    check("hold rem1",  32'(bus.o_remainder), 32'd0);
    @(negedge clk);
    check("hold gap ret",  32'(bus.o_returning), 32'd0);
    check("hold gap done", 32'(bus.o_done), 32'd0);
    @(negedge clk);
    bus.i_trigger_return = 1'b0;
    check("hold coin2", 32'(bus.o_return_coin), 32'b010);
    bus.current_total = bus.current_total - 31'd500;
    @(negedge clk);
    check("hold done2", 32'(bus.o_done), 32'd1);
    check("hold rem2",  32'(bus.o_remainder), 32'd0);
    @(negedge clk);

    for (int it = 0; it < 30; it++) begin
      int unsigned total;
      bit          by_timer;
      total    = (it % 5 == 0) ? $urandom_range(0, 150) : $urandom_range(0, 12000);
      by_timer = (total >= kC0) && ($urandom_range(0, 1) == 1);
      run_return(total, by_timer, $sformatf("rand%0d", it));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
